// File: rtl/alu_pkg.sv
// Shared ALU op-codes and multiplier FSM state encoding.
// Optional signed support via ALU_MUL_SIGNED_EN adds the negate states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  // Index of the final shift-add step; RUN therefore lasts 32 cycles.
  localparam logic [4:0] LAST_STEP = 5'd31;

`ifdef ALU_MUL_SIGNED_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_RUN,
    S_NEG_LO,
    S_NEG_HI,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;
`endif

endpackage

// File: rtl/alu_mul_dp.sv
// Multiplier datapath: multiplicand, accumulator/shift register and ALU steering.
// ALU_MUL_SIGNED_EN adds the operand and result negation steps.
module alu_mul_dp
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  state_t      state,
  input  logic        load,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_binvert,
  output logic        alu_carryin,
  output logic [1:0]  alu_op,
  output logic [63:0] product
);

  logic [31:0] mcand_reg;
  logic [63:0] acc_reg;
  logic [63:0] shifted;
`ifdef ALU_MUL_SIGNED_EN
  logic        carry_reg;
`endif

  // {c,hi,lo} >> 1, where {c,hi} is the ALU sum only when the low bit is set.
  always_comb begin
    if (acc_reg[0]) shifted = {alu_cout, alu_result, acc_reg[31:1]};
    else            shifted = {1'b0, acc_reg[63:1]};
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_binvert = 1'b0;
    alu_carryin = 1'b0;
    alu_op      = OP_AND;
    case (state)
      S_RUN: begin
        alu_a  = acc_reg[63:32];
        alu_b  = mcand_reg;
        alu_op = OP_ADD;
      end
`ifdef ALU_MUL_SIGNED_EN
      S_NEG_A: begin
        alu_b       = mcand_reg;
        alu_op      = OP_ADD;
        alu_binvert = 1'b1;
        alu_carryin = 1'b1;
      end
      S_NEG_B, S_NEG_LO: begin
        alu_b       = acc_reg[31:0];
        alu_op      = OP_ADD;
        alu_binvert = 1'b1;
        alu_carryin = 1'b1;
      end
      S_NEG_HI: begin
        alu_b       = acc_reg[63:32];
        alu_op      = OP_ADD;
        alu_binvert = 1'b1;
        alu_carryin = carry_reg;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg <= '0;
      acc_reg   <= '0;
`ifdef ALU_MUL_SIGNED_EN
      carry_reg <= 1'b0;
`endif
    end else if (load) begin
      mcand_reg <= a_in;
      acc_reg   <= {32'd0, b_in};
`ifdef ALU_MUL_SIGNED_EN
      carry_reg <= 1'b0;
`endif
    end else begin
      case (state)
        S_RUN: acc_reg <= shifted;
`ifdef ALU_MUL_SIGNED_EN
        S_NEG_A:  mcand_reg <= alu_result;
        S_NEG_B:  acc_reg[31:0] <= alu_result;
        S_NEG_LO: begin
          acc_reg[31:0] <= alu_result;
          carry_reg     <= alu_cout;
        end
        S_NEG_HI: acc_reg[63:32] <= alu_result;
`endif
        default: ;
      endcase
    end
  end

  assign product = acc_reg;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-add multiplier driving an external 32-bit ALU.
// Define ALU_MUL_SIGNED_EN for two's-complement support via signed_in.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef ALU_MUL_SIGNED_EN
  input  logic        signed_in,
`endif
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_binvert,
  output logic        alu_carryin,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] count_reg;
  logic       accept;

  assign accept = start && (state_reg == S_IDLE);

`ifdef ALU_MUL_SIGNED_EN
  logic neg_b_reg;
  logic flip_reg;

  // Operand signs are latched at start; the operands themselves get overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_b_reg <= 1'b0;
      flip_reg  <= 1'b0;
    end else if (accept) begin
      neg_b_reg <= signed_in & b_in[31];
      flip_reg  <= signed_in & (a_in[31] ^ b_in[31]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)                  count_reg <= '0;
      else if (state_reg == S_RUN) count_reg <= count_reg + 5'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_SIGNED_EN
          if (signed_in && a_in[31])      state_next = S_NEG_A;
          else if (signed_in && b_in[31]) state_next = S_NEG_B;
          else                            state_next = S_RUN;
`else
          state_next = S_RUN;
`endif
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      S_NEG_A:  state_next = neg_b_reg ? S_NEG_B : S_RUN;
      S_NEG_B:  state_next = S_RUN;
      S_RUN:    if (count_reg == LAST_STEP) state_next = flip_reg ? S_NEG_LO : S_DONE;
      S_NEG_LO: state_next = S_NEG_HI;
      S_NEG_HI: state_next = S_DONE;
`else
      S_RUN:    if (count_reg == LAST_STEP) state_next = S_DONE;
`endif
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE);

  alu_mul_dp u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state_reg),
    .load        (accept),
    .a_in        (a_in),
    .b_in        (b_in),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_binvert (alu_binvert),
    .alu_carryin (alu_carryin),
    .alu_op      (alu_op),
    .product     (product)
  );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a behavioural 32-bit ALU and arithmetic product model.
// Signed scenarios are compiled in when ALU_MUL_SIGNED_EN is defined.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_binvert;
  logic        alu_carryin;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_cout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef ALU_MUL_SIGNED_EN
    .signed_in   (signed_in),
`endif
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_binvert (alu_binvert),
    .alu_carryin (alu_carryin),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  // The external ALU the multiplier is wired to.
  logic [31:0] bsel;
  logic [32:0] sum;
  always_comb begin
    bsel       = alu_binvert ? ~alu_b : alu_b;
    sum        = {1'b0, alu_a} + {1'b0, bsel} + {32'd0, alu_carryin};
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      2'b00: alu_result = alu_a & bsel;
      2'b01: alu_result = alu_a | bsel;
      2'b10: begin
        alu_result = sum[31:0];
        alu_cout   = sum[32];
      end
      default: ;
    endcase
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Issues one start, returns the product at the done pulse and the cycle it arrived in.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] prod, output int lat);
    @(posedge clk); #1;
    a_in = a; b_in = b; signed_in = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom; signed_in = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; signed_in = 1'b0; a_in = '0; b_in = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (product !== 64'd0) begin n_err++; $display("FAIL reset_product: got %h expected 0", product); end
    n_vec++;
    if ({alu_a, alu_b, alu_binvert, alu_carryin, alu_op} !== 68'd0) begin
      n_err++; $display("FAIL reset_alu: got a=%h b=%h bi=%b ci=%b op=%b expected all 0",
                        alu_a, alu_b, alu_binvert, alu_carryin, alu_op);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    @(posedge clk); #1;
    a_in = 32'd3; b_in = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
    n_vec++;
    if ({alu_a, alu_b, alu_binvert, alu_carryin, alu_op} !== {32'd0, 32'd3, 1'b0, 1'b0, 2'b10}) begin
      n_err++; $display("FAIL basic_run_alu: got a=%h b=%h bi=%b ci=%b op=%b expected a=0 b=3 bi=0 ci=0 op=10",
                        alu_a, alu_b, alu_binvert, alu_carryin, alu_op);
    end
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      n_vec++; if (!done && busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_cycle%0d: got %b expected 1", lat + 1, busy); end
      lat++;
    end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    n_vec++; if (product !== 64'hF) begin n_err++; $display("FAIL basic_product: got %h expected %h", product, 64'hF); end
    @(posedge clk); #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done); end
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (product !== 64'hF) begin n_err++; $display("FAIL basic_hold: got %h expected %h", product, 64'hF); end
    n_vec++;
    if ({alu_a, alu_b, alu_binvert, alu_carryin, alu_op} !== 68'd0) begin
      n_err++; $display("FAIL idle_alu: got a=%h b=%h op=%b expected all 0", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_corners();
    logic [31:0] ca [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h8000_0000};
    logic [31:0] cb [4] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h2};
    logic [63:0] want [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0, 64'h1_0000_0000};
    logic [63:0] prod;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ca[i], cb[i], 1'b0, prod, lat);
      n_vec++; if (prod !== want[i]) begin n_err++; $display("FAIL corner%0d_product: got %h expected %h", i, prod, want[i]); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL corner%0d_latency: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int lat;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) b = 32'd1;
      run_op(a, b, 1'b0, prod, lat);
      n_vec++; if (prod !== ref_mul(a, b, 1'b0)) begin n_err++; $display("FAIL rand%0d_product a=%h b=%h: got %h expected %h", i, a, b, prod, ref_mul(a, b, 1'b0)); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(posedge clk); #1;
    a_in = 32'd7; b_in = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    a_in = 32'd11; b_in = 32'd13;
    lat = 1;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++; if (product !== 64'd63) begin n_err++; $display("FAIL b2b_first_product: got %h expected %h", product, 64'd63); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 33", lat); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); end
    n_vec++; if (product !== 64'd63) begin n_err++; $display("FAIL b2b_gap_product: got %h expected %h", product, 64'd63); end
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy); end
    lat = 1;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++; if (product !== 64'd143) begin n_err++; $display("FAIL b2b_second_product: got %h expected %h", product, 64'd143); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] prod;
    int lat;
    bit saw_done;
    @(posedge clk); #1;
    a_in = 32'hDEAD_BEEF; b_in = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_state: got busy=%b done=%b expected 0 0", busy, done); end
    n_vec++; if (product !== 64'd0) begin n_err++; $display("FAIL midrst_product: got %h expected 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got activity=%b expected 0", saw_done); end
    run_op(32'd6, 32'd7, 1'b0, prod, lat);
    n_vec++; if (prod !== 64'd42) begin n_err++; $display("FAIL midrst_recover: got %h expected %h", prod, 64'd42); end
  endtask

`ifdef ALU_MUL_SIGNED_EN
  task automatic test_signed();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] prod;
    int lat;
    int want_lat;
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, prod, lat);
    n_vec++; if (prod !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL signed_m3x7: got %h expected %h", prod, 64'hFFFF_FFFF_FFFF_FFEB); end
    n_vec++; if (lat !== 36) begin n_err++; $display("FAIL signed_m3x7_latency: got %0d expected 36", lat); end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, prod, lat);
    n_vec++; if (prod !== 64'h4000_0000_0000_0000) begin n_err++; $display("FAIL signed_minxmin: got %h expected %h", prod, 64'h4000_0000_0000_0000); end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; s = (i != 7);
      if (i == 0) a = 32'h8000_0000;
      run_op(a, b, s, prod, lat);
      want_lat = 33 + int'(s & a[31]) + int'(s & b[31]) + 2 * int'(s & (a[31] ^ b[31]));
      n_vec++; if (prod !== ref_mul(a, b, s)) begin n_err++; $display("FAIL srand%0d_product a=%h b=%h s=%b: got %h expected %h", i, a, b, s, prod, ref_mul(a, b, s)); end
      n_vec++; if (lat !== want_lat) begin n_err++; $display("FAIL srand%0d_latency: got %0d expected %0d", i, lat, want_lat); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ALU_MUL_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
